// File: rtl/hex_counter_keys.sv
// Debounced push-button front end driving a wrapping 4-bit hex counter for the 7-segment decoder.
// Optional auto-repeat of the up/down keys is enabled by defining AUTO_REPEAT_EN.
module hex_counter_keys #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 10000000
) (
   input  logic       CLOCK_50,
   input  logic       RESET_N,
   input  logic       KEY_UP_N,
   input  logic       KEY_DN_N,
   input  logic       KEY_LD_N,
   input  logic [3:0] SW,
   output logic [3:0] DIGIT,
   output logic       STEP,
   output logic       CARRY
);

   localparam int unsigned NKEYS = 3;
   localparam int unsigned KUP   = 0;
   localparam int unsigned KDN   = 1;
   localparam int unsigned KLD   = 2;
   localparam int unsigned CW    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_SAT  = CW'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } db_state_e;

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
      $error("hex_counter_keys: illegal parameter value");
   end

   logic [NKEYS-1:0] keys_n;
   logic [NKEYS-1:0] sync1_q;
   logic [NKEYS-1:0] sync2_q;
   logic [NKEYS-1:0] pressed;
   logic [NKEYS-1:0] press_c;
   logic [NKEYS-1:0] pulse_c;
   db_state_e        state_q [NKEYS];
   db_state_e        state_d [NKEYS];
   logic [CW-1:0]    cnt_q   [NKEYS];
   logic [CW-1:0]    cnt_d   [NKEYS];

   assign keys_n = {KEY_LD_N, KEY_DN_N, KEY_UP_N};

   // Two-flop synchronisers; reset to the released level
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= keys_n;
         sync2_q <= sync1_q;
      end
   end

   assign pressed = ~sync2_q;

   // Debounce state registers
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int unsigned k = 0; k < NKEYS; k++) begin
            state_q[k] <= IDLE;
            cnt_q[k]   <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < NKEYS; k++) begin
            state_q[k] <= state_d[k];
            cnt_q[k]   <= cnt_d[k];
         end
      end
   end

   // Debounce next-state; press pulse fires on the last stable sample of PRESS_WAIT
   always_comb begin
      press_c = '0;
      for (int unsigned k = 0; k < NKEYS; k++) begin
         state_d[k] = state_q[k];
         cnt_d[k]   = cnt_q[k];
         unique case (state_q[k])
            IDLE: begin
               if (pressed[k]) begin
                  state_d[k] = PRESS_WAIT;
                  cnt_d[k]   = '0;
               end
            end
            PRESS_WAIT: begin
               if (!pressed[k]) begin
                  state_d[k] = IDLE;
               end else if (cnt_q[k] == CNT_LAST) begin
                  state_d[k] = HELD;
                  press_c[k] = 1'b1;
               end else if (cnt_q[k] != CNT_SAT) begin
                  cnt_d[k] = cnt_q[k] + CW'(1);
               end
            end
            HELD: begin
               if (!pressed[k]) begin
                  state_d[k] = RELEASE_WAIT;
                  cnt_d[k]   = '0;
               end
            end
            RELEASE_WAIT: begin
               if (pressed[k]) begin
                  state_d[k] = HELD;
               end else if (cnt_q[k] == CNT_LAST) begin
                  state_d[k] = IDLE;
               end else if (cnt_q[k] != CNT_SAT) begin
                  cnt_d[k] = cnt_q[k] + CW'(1);
               end
            end
         endcase
      end
   end

`ifdef AUTO_REPEAT_EN
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned HW   = $clog2(RMAX + 1);
   localparam logic [HW-1:0] HOLD_FIRST = HW'(REPEAT_DELAY - 1);
   localparam logic [HW-1:0] HOLD_NEXT  = HW'(REPEAT_PERIOD - 1);

   logic [HW-1:0] hold_q [2];
   logic [HW-1:0] hold_d [2];
   logic [1:0]    rep_q;
   logic [1:0]    rep_d;
   logic [1:0]    rep_c;

   // Hold counters for up/down only; cleared whenever the key is not staying in HELD
   always_comb begin
      rep_d = rep_q;
      rep_c = '0;
      for (int unsigned k = 0; k < 2; k++) begin
         hold_d[k] = hold_q[k];
         if (state_q[k] == HELD && pressed[k]) begin
            if (hold_q[k] == (rep_q[k] ? HOLD_NEXT : HOLD_FIRST)) begin
               rep_c[k]  = 1'b1;
               rep_d[k]  = 1'b1;
               hold_d[k] = '0;
            end else begin
               hold_d[k] = hold_q[k] + HW'(1);
            end
         end else begin
            rep_d[k]  = 1'b0;
            hold_d[k] = '0;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         rep_q     <= '0;
         hold_q[0] <= '0;
         hold_q[1] <= '0;
      end else begin
         rep_q     <= rep_d;
         hold_q[0] <= hold_d[0];
         hold_q[1] <= hold_d[1];
      end
   end

   assign pulse_c = press_c | {1'b0, rep_c};
`else
   assign pulse_c = press_c;
`endif

   // Counter update: load wins, simultaneous up/down cancel
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         DIGIT <= 4'h0;
         STEP  <= 1'b0;
         CARRY <= 1'b0;
      end else begin
         STEP  <= 1'b0;
         CARRY <= 1'b0;
         if (pulse_c[KLD]) begin
            DIGIT <= SW;
            STEP  <= 1'b1;
         end else if (pulse_c[KUP] && !pulse_c[KDN]) begin
            DIGIT <= DIGIT + 4'd1;
            STEP  <= 1'b1;
            CARRY <= (DIGIT == 4'hF);
         end else if (pulse_c[KDN] && !pulse_c[KUP]) begin
            DIGIT <= DIGIT - 4'd1;
            STEP  <= 1'b1;
            CARRY <= (DIGIT == 4'h0);
         end
      end
   end

endmodule

// File: tb/tb_hex_counter_keys.sv
// Directed bench for hex_counter_keys with short debounce/repeat parameters.
module tb_hex_counter_keys;

   logic       CLOCK_50;
   logic       RESET_N;
   logic       KEY_UP_N;
   logic       KEY_DN_N;
   logic       KEY_LD_N;
   logic [3:0] SW;
   logic [3:0] DIGIT;
   logic       STEP;
   logic       CARRY;

   int checks   = 0;
   int failures = 0;

   hex_counter_keys #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (20),
      .REPEAT_PERIOD  (8)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .RESET_N (RESET_N),
      .KEY_UP_N(KEY_UP_N),
      .KEY_DN_N(KEY_DN_N),
      .KEY_LD_N(KEY_LD_N),
      .SW      (SW),
      .DIGIT   (DIGIT),
      .STEP    (STEP),
      .CARRY   (CARRY)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic release_and_settle();
      KEY_UP_N = 1'b1;
      KEY_DN_N = 1'b1;
      KEY_LD_N = 1'b1;
      repeat (20) tick();
   endtask

   task automatic test_reset();
      RESET_N  = 1'b0;
      KEY_UP_N = 1'b1;
      KEY_DN_N = 1'b1;
      KEY_LD_N = 1'b1;
      SW       = 4'h0;
      repeat (3) tick();
      checks++;
      if (DIGIT !== 4'h0 || STEP !== 1'b0 || CARRY !== 1'b0) begin
         failures++;
         $display("FAIL reset_values digit=%0h step=%0b carry=%0b required 0 0 0", DIGIT, STEP, CARRY);
      end
      RESET_N = 1'b1;
      for (int i = 1; i <= 50; i++) begin
         tick();
         checks++;
         if (DIGIT !== 4'h0 || STEP !== 1'b0 || CARRY !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle cycle=%0d digit=%0h step=%0b carry=%0b required 0 0 0",
                     i, DIGIT, STEP, CARRY);
         end
      end
   endtask

   task automatic test_glitch();
      KEY_UP_N = 1'b0;
      repeat (3) tick();
      KEY_UP_N = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         checks++;
         if (DIGIT !== 4'h0 || STEP !== 1'b0) begin
            failures++;
            $display("FAIL glitch cycle=%0d digit=%0h step=%0b required 0 0", i, DIGIT, STEP);
         end
      end
   endtask

   task automatic test_single_press();
      KEY_UP_N = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         checks++;
         if (DIGIT !== 4'h0 || STEP !== 1'b0) begin
            failures++;
            $display("FAIL press_latency cycle=%0d digit=%0h step=%0b required 0 0", i, DIGIT, STEP);
         end
      end
      tick();
      checks++;
      if (DIGIT !== 4'h1 || STEP !== 1'b1 || CARRY !== 1'b0) begin
         failures++;
         $display("FAIL press_step digit=%0h step=%0b carry=%0b required 1 1 0", DIGIT, STEP, CARRY);
      end
      repeat (3) tick();
      KEY_UP_N = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         checks++;
         if (DIGIT !== 4'h1 || STEP !== 1'b0) begin
            failures++;
            $display("FAIL press_release cycle=%0d digit=%0h step=%0b required 1 0", i, DIGIT, STEP);
         end
      end
   endtask

   task automatic test_release_bounce();
      KEY_UP_N = 1'b0;
      repeat (7) tick();
      checks++;
      if (DIGIT !== 4'h2 || STEP !== 1'b1) begin
         failures++;
         $display("FAIL bounce_press digit=%0h step=%0b required 2 1", DIGIT, STEP);
      end
      repeat (3) tick();
      for (int b = 0; b < 2; b++) begin
         KEY_UP_N = 1'b1;
         repeat (2) tick();
         KEY_UP_N = 1'b0;
         for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (DIGIT !== 4'h2 || STEP !== 1'b0) begin
               failures++;
               $display("FAIL bounce_hold b=%0d digit=%0h step=%0b required 2 0", b, DIGIT, STEP);
            end
         end
      end
      KEY_UP_N = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         checks++;
         if (DIGIT !== 4'h2 || STEP !== 1'b0) begin
            failures++;
            $display("FAIL bounce_release cycle=%0d digit=%0h step=%0b required 2 0", i, DIGIT, STEP);
         end
      end
   endtask

   task automatic test_wrap();
      SW       = 4'hF;
      KEY_LD_N = 1'b0;
      repeat (7) tick();
      checks++;
      if (DIGIT !== 4'hF || STEP !== 1'b1 || CARRY !== 1'b0) begin
         failures++;
         $display("FAIL load_f digit=%0h step=%0b carry=%0b required f 1 0", DIGIT, STEP, CARRY);
      end
      release_and_settle();
      KEY_UP_N = 1'b0;
      repeat (7) tick();
      checks++;
      if (DIGIT !== 4'h0 || STEP !== 1'b1 || CARRY !== 1'b1) begin
         failures++;
         $display("FAIL wrap_up digit=%0h step=%0b carry=%0b required 0 1 1", DIGIT, STEP, CARRY);
      end
      tick();
      checks++;
      if (DIGIT !== 4'h0 || STEP !== 1'b0 || CARRY !== 1'b0) begin
         failures++;
         $display("FAIL wrap_up_width digit=%0h step=%0b carry=%0b required 0 0 0", DIGIT, STEP, CARRY);
      end
      release_and_settle();
      KEY_DN_N = 1'b0;
      repeat (7) tick();
      checks++;
      if (DIGIT !== 4'hF || STEP !== 1'b1 || CARRY !== 1'b1) begin
         failures++;
         $display("FAIL wrap_down digit=%0h step=%0b carry=%0b required f 1 1", DIGIT, STEP, CARRY);
      end
      release_and_settle();
      KEY_DN_N = 1'b0;
      repeat (7) tick();
      checks++;
      if (DIGIT !== 4'hE || STEP !== 1'b1 || CARRY !== 1'b0) begin
         failures++;
         $display("FAIL down_plain digit=%0h step=%0b carry=%0b required e 1 0", DIGIT, STEP, CARRY);
      end
      release_and_settle();
      KEY_UP_N = 1'b0;
      repeat (7) tick();
      checks++;
      if (DIGIT !== 4'hF || STEP !== 1'b1 || CARRY !== 1'b0) begin
         failures++;
         $display("FAIL up_plain digit=%0h step=%0b carry=%0b required f 1 0", DIGIT, STEP, CARRY);
      end
      release_and_settle();
   endtask

   task automatic test_simultaneous();
      KEY_UP_N = 1'b0;
      KEY_DN_N = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         checks++;
         if (DIGIT !== 4'hF || STEP !== 1'b0 || CARRY !== 1'b0) begin
            failures++;
            $display("FAIL up_dn_cancel cycle=%0d digit=%0h step=%0b carry=%0b required f 0 0",
                     i, DIGIT, STEP, CARRY);
         end
      end
      release_and_settle();
      SW       = 4'h9;
      KEY_LD_N = 1'b0;
      KEY_UP_N = 1'b0;
      repeat (7) tick();
      checks++;
      if (DIGIT !== 4'h9 || STEP !== 1'b1 || CARRY !== 1'b0) begin
         failures++;
         $display("FAIL load_over_up digit=%0h step=%0b carry=%0b required 9 1 0", DIGIT, STEP, CARRY);
      end
      tick();
      checks++;
      if (DIGIT !== 4'h9 || STEP !== 1'b0) begin
         failures++;
         $display("FAIL load_over_up_after digit=%0h step=%0b required 9 0", DIGIT, STEP);
      end
      release_and_settle();
      KEY_LD_N = 1'b0;
      repeat (7) tick();
      checks++;
      if (DIGIT !== 4'h9 || STEP !== 1'b1 || CARRY !== 1'b0) begin
         failures++;
         $display("FAIL load_same digit=%0h step=%0b carry=%0b required 9 1 0", DIGIT, STEP, CARRY);
      end
      release_and_settle();
   endtask

   task automatic test_reset_mid();
      KEY_UP_N = 1'b0;
      repeat (4) tick();
      RESET_N = 1'b0;
      #1;
      checks++;
      if (DIGIT !== 4'h0 || STEP !== 1'b0 || CARRY !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_async digit=%0h step=%0b carry=%0b required 0 0 0", DIGIT, STEP, CARRY);
      end
      repeat (2) tick();
      RESET_N = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         checks++;
         if (DIGIT !== 4'h0 || STEP !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_wait cycle=%0d digit=%0h step=%0b required 0 0", i, DIGIT, STEP);
         end
      end
      tick();
      checks++;
      if (DIGIT !== 4'h1 || STEP !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_press digit=%0h step=%0b required 1 1", DIGIT, STEP);
      end
      release_and_settle();
      KEY_DN_N = 1'b0;
      repeat (7) tick();
      checks++;
      if (DIGIT !== 4'h0 || STEP !== 1'b1 || CARRY !== 1'b0) begin
         failures++;
         $display("FAIL down_to_zero digit=%0h step=%0b carry=%0b required 0 1 0", DIGIT, STEP, CARRY);
      end
      release_and_settle();
   endtask

`ifdef AUTO_REPEAT_EN
   task automatic test_auto_repeat();
      logic [3:0] exp;
      KEY_UP_N = 1'b0;
      for (int i = 1; i <= 54; i++) begin
         tick();
         exp = 4'((i >= 7) + (i >= 27) + (i >= 35) + (i >= 43) + (i >= 51));
         checks++;
         if (DIGIT !== exp) begin
            failures++;
            $display("FAIL auto_repeat cycle=%0d digit=%0h required %0h", i, DIGIT, exp);
         end
      end
      release_and_settle();
      checks++;
      if (DIGIT !== 4'h5) begin
         failures++;
         $display("FAIL auto_repeat_final digit=%0h required 5", DIGIT);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_glitch();
      test_single_press();
      test_release_bounce();
      test_wrap();
      test_simultaneous();
      test_reset_mid();
`ifdef AUTO_REPEAT_EN
      test_auto_repeat();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation exceeded time limit");
      $fatal(1);
   end

endmodule
